data_ram_pipe: RTL
==================

# data_ram_pipe

Parametrised, byte-enabled, single-port data RAM for the back-end memory stage with a valid/ready request channel and a valid/ready response channel. It generalises the fixed 32-bit x 1024-entry data RAM to configurable width and depth. It adds a registered one-cycle read latency, response back-pressure, out-of-range address error reporting, and an optional hardware clear sweep. It sits between the LSU/MEM stage and on-chip data storage.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8; BANKS = DATA_WIDTH/8 byte lanes
- DEPTH, 1024, words; power of two; IDX_W = log2(DEPTH)
- ADDR_WIDTH, 32, byte-address width; OFF_W = log2(BANKS)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ram_en  in  1  block enable; 0 blocks new requests
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address; low OFF_W bits ignored
- req_sel  in  BANKS  byte-lane write enables
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  address out of range
- busy  out  1  clear sweep in progress; constant 0 without macro

## Operation
- Index = req_addr[OFF_W+IDX_W-1:OFF_W].
- Out of range: any bit of req_addr above OFF_W+IDX_W is set.
- Handshake: a request is accepted on an edge with req_valid && req_ready.
- req_ready = ram_en && !busy && (!resp_valid || resp_ready). This is combinational, with no dependence on req_valid.
- Accepted write, in range: each lane i with req_sel[i]=1 writes req_wdata[8i+7:8i] at that edge. req_sel=0 is a legal no-op.
- Accepted read, in range: the word at index is captured into resp_rdata at the acceptance edge.
- Out of range, read or write: storage is untouched; response has resp_err=1 and resp_rdata=0.
- Every accepted request produces exactly one response, in order. At most one response is held at a time.
- Response holding: resp_valid, resp_rdata and resp_err stay stable until the edge with resp_valid && resp_ready.
- Simultaneous events: if a new request is accepted on the same edge, the response register reloads; otherwise resp_valid clears.
- ram_en=0: no new acceptances. A held response is still delivered.
- Storage contents are not reset.

## Timing
- Read latency: request accepted at edge N gives resp_valid=1 in cycle N+1.
- Throughput: one request per cycle while resp_ready=1.
- Read-after-write: a read accepted at edge N+1 returns data written at edge N.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- Reset asserted mid-transaction: the held response is dropped. A write whose edge coincides with reset assertion is not guaranteed.

## Configuration
- DATA_RAM_CLEAR_EN defined:
  - Adds input clr_req (1 bit).
  - FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1 and no response is held, and also automatically on reset deassertion.
  - In CLEAR, busy=1 and req_ready=0. An index counter writes 0 to all lanes of entries 0..DEPTH-1, one per cycle.
  - CLEAR -> IDLE after entry DEPTH-1 is written. Sweep length is exactly DEPTH cycles.
  - clr_req during CLEAR is ignored. Reset during CLEAR restarts the sweep from 0.
- DATA_RAM_CLEAR_EN undefined: no clr_req port, no FSM, busy tied to 0, contents undefined after power-up.

## Test plan
- Write 0xDEADBEEF to addr 0x10 with sel=4'b1111, then read 0x10 -> response one cycle later: rdata=0xDEADBEEF, err=0.
- Then write 0x00AA0000 to 0x10 with sel=4'b0100, then read -> rdata=0xDEAABEEF.
- Read addr 0x1000 (DEPTH=1024) -> err=1, rdata=0; a write to 0x1000 with sel=4'b1111 leaves entry 0 unchanged.
- Back-pressure:
  - Hold resp_ready=0 after a read of 0x10 -> req_ready=0; resp_rdata stays stable for 5 cycles.
  - Raise resp_ready together with a new read of 0x14 -> both handshakes happen on the same edge; the next response is entry 5.
- ram_en=0 with req_valid=1 -> req_ready=0 and no write; a held response still completes.
- With DATA_RAM_CLEAR_EN:
  - Release rst_n -> busy=1 for exactly 1024 cycles; a read of any in-range address afterwards returns 0.
  - Assert rst_n=0 at sweep cycle 300 -> the sweep restarts from index 0.

Source files
------------

// File: rtl/data_ram_pipe.sv
// Byte-enabled single-port data RAM with valid/ready request and response channels.
// Optional power-up/on-demand clear sweep is built when DATA_RAM_CLEAR_EN is defined.
module data_ram_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ram_en,
`ifdef DATA_RAM_CLEAR_EN
  input  logic                    clr_req,
`endif
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int BANKS = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BANKS);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP_W = OFF_W + IDX_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             oor;
  logic             accept;
  logic             do_write;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  assign idx = req_addr[TOP_W-1:OFF_W];

  // Any address bit beyond the storage span flags the request as out of range.
  generate
    if (ADDR_WIDTH > TOP_W) begin : g_oor
      assign oor = |req_addr[ADDR_WIDTH-1:TOP_W];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
    if (OFF_W > 0) begin : g_off
      logic unused_offset;
      assign unused_offset = ^req_addr[OFF_W-1:0];
    end
  endgenerate

  assign req_ready = ram_en && !busy && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign do_write  = accept && req_write && !oor;

`ifdef DATA_RAM_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0] state;
  logic       boot_pending;

  // boot_pending launches the sweep on the first edge after reset release,
  // keeping busy low while reset is still asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      boot_pending <= 1'b1;
      clr_idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (boot_pending || (clr_req && !resp_valid)) begin
            state        <= ST_CLEAR;
            boot_pending <= 1'b0;
            clr_idx      <= '0;
          end
        end
        default: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state == ST_CLEAR);
  assign clr_we = busy;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // NOTE: storage has no reset branch so it maps onto RAM macros; only the
  // control and response registers are reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < BANKS; i++) begin
        if (req_sel[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Response register: reloads on acceptance, otherwise drains on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= oor;
      resp_rdata <= (!req_write && !oor) ? mem[idx] : '0;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
